// File: rtl/apb_router_if.sv
// rtl/apb_router_if.sv - master-side APB bus bundle for apb_router
//
// Purpose : groups the APB request/response signals between one master and
//           the router.
// Modports: master - drives paddr/pdata/pstb/psel/penable/pwrite,
//                    samples prdata/pready/perr
//           slave  - the router side, mirror image of master
interface apb_router_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pdata;
  logic [DATA_WIDTH/8-1:0] pstb;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    perr;

  modport master (
    output paddr, pdata, pstb, psel, penable, pwrite,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, pstb, psel, penable, pwrite,
    output prdata, pready, perr
  );
endinterface

// File: rtl/apb_router.sv
// rtl/apb_router.sv - APB 1-to-N address-decoding router with error capture
//
// Purpose : decodes the master address onto one of NUM_SLAVES slave ports,
//           returns that slave's response, answers decode misses itself and
//           (optionally) aborts transfers to slaves that never become ready.
// Ports   : clk, rts      - clock, synchronous active-high reset
//           m_apb         - master APB bus (apb_router_if.slave)
//           s_sel/s_enable- per-slave select / enable
//           s_data        - per-slave read data, slave i in slice i
//           s_ready/s_perr- per-slave ready / error
//           err_valid/err_addr/err_clr - sticky router-error record
// Config  : define APB_ROUTER_TIMEOUT_EN to build the ACCESS timeout counter
//           and the ERR response; without it a silent slave stalls the bus.
module apb_router #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  // Slice i (bits [i*ADDR_WIDTH +: ADDR_WIDTH]) belongs to slave i:
  // slave0 = 0x0/0x8000_0000, slave1 = 0x8000_0000, slave2 = 0x9000_0000,
  // slave3 = 0xA000_0000 (the last three with mask 0xF000_0000).
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'hA000_0000, 32'h9000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h8000_0000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rts,
  apb_router_if.slave                      m_apb,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [NUM_SLAVES-1:0]            s_enable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  input  logic [NUM_SLAVES-1:0]            s_perr,
  output logic                             err_valid,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  input  logic                             err_clr
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    miss_q, miss_d;
  logic                    err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

  logic [IDX_W-1:0]        dec_idx;
  logic                    dec_miss;
  logic                    err_event;
  logic [NUM_SLAVES-1:0]   sel_c, en_c;
  logic                    pready_c, perr_c;
  logic [DATA_WIDTH-1:0]   prdata_c;

`ifdef APB_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  // Write data and strobes are not routed; slaves take them from the master bus.
  logic unused_wr_path;
  assign unused_wr_path = ^{m_apb.pdata, m_apb.pstb, m_apb.pwrite};

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_idx  = '0;
    dec_miss = 1'b1;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_apb.paddr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        dec_idx  = IDX_W'(i);
        dec_miss = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    miss_d    = miss_q;
    sel_c     = '0;
    en_c      = '0;
    pready_c  = 1'b0;
    perr_c    = 1'b0;
    prdata_c  = '0;
    err_event = 1'b0;
`ifdef APB_ROUTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (m_apb.psel && !m_apb.penable) begin
          state_d = SETUP;
          idx_d   = dec_idx;
          miss_d  = dec_miss;
        end
      end
      SETUP: begin
        if (!miss_q) sel_c[idx_q] = m_apb.psel;
        state_d = m_apb.psel ? ACCESS : IDLE;
`ifdef APB_ROUTER_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (miss_q) begin
          pready_c = 1'b1;
          perr_c   = 1'b1;
        end else begin
          sel_c[idx_q] = m_apb.psel;
          en_c[idx_q]  = m_apb.penable;
          pready_c     = s_ready[idx_q];
          perr_c       = s_perr[idx_q];
          prdata_c     = s_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
        end
        // A master that drops psel loses its transfer silently.
        if (!m_apb.psel) begin
          state_d = IDLE;
        end else if (pready_c) begin
          state_d   = IDLE;
          err_event = miss_q;
        end
`ifdef APB_ROUTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ERR;
          err_event = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ERR: begin
        pready_c = 1'b1;
        perr_c   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new error in the same cycle as err_clr overrides the clear.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (err_event && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_addr_d  = m_apb.paddr;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rts) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      miss_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      miss_q      <= miss_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

`ifdef APB_ROUTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rts) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  // Reset silences every output in the same cycle, not just after the edge.
  assign s_sel        = rts ? '0   : sel_c;
  assign s_enable     = rts ? '0   : en_c;
  assign m_apb.pready = rts ? 1'b0 : pready_c;
  assign m_apb.perr   = rts ? 1'b0 : perr_c;
  assign m_apb.prdata = rts ? '0   : prdata_c;
  assign err_valid    = err_valid_q;
  assign err_addr     = err_addr_q;
endmodule

// File: tb/tb_apb_router.sv
// tb/tb_apb_router.sv - directed scoreboard bench for apb_router
module tb_apb_router;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rts;
  logic [NS-1:0]     s_sel, s_enable, s_ready, s_perr;
  logic [NS*DW-1:0]  s_data;
  logic              err_valid;
  logic [AW-1:0]     err_addr;
  logic              err_clr;

  apb_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_router #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rts(rts), .m_apb(bus),
    .s_sel(s_sel), .s_enable(s_enable), .s_data(s_data),
    .s_ready(s_ready), .s_perr(s_perr),
    .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
  );

  // Slave model: ready once slave_wait ACCESS cycles have elapsed.
  int slave_wait;
  int acc_cnt [NS];
  always @(posedge clk)
    for (int i = 0; i < NS; i++)
      acc_cnt[i] <= (s_sel[i] && s_enable[i]) ? acc_cnt[i] + 1 : 0;
  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NS; i++)
      s_ready[i] = s_sel[i] & s_enable[i] & (acc_cnt[i] == slave_wait);
  end

  typedef struct packed { logic [DW-1:0] data; logic err; } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic xfer(input logic [AW-1:0] addr, input bit wr,
                      input logic [DW-1:0] exp_data, input bit exp_err,
                      input bit clr_at_resp,
                      output int waits, output logic [NS-1:0] rsel,
                      output logic [NS-1:0] ren);
    exp_t e;
    bit   done;
    exp_q.push_back({exp_data, exp_err});
    rsel = '0;
    ren  = '0;
    @(posedge clk); #1;
    bus.paddr = addr; bus.pwrite = wr; bus.pdata = $urandom; bus.pstb = '1;
    bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      err_clr = clr_at_resp && (c == 0);
      @(negedge clk);
      if (bus.pready === 1'b1) begin
        done = 1'b1;
        rsel = s_sel;
        ren  = s_enable;
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("prdata", bus.prdata, e.data);
          check("perr", bus.perr, e.err);
        end
      end else begin
        waits++;
      end
    end
    if (!done) begin
      check("resp_bound", done, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    check("pready_one_cycle", bus.pready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [NS-1:0] rs, re;

    rts = 1'b1; err_clr = 1'b0; slave_wait = 0; s_perr = '0;
    s_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_AAAA};
    bus.paddr = 32'h10; bus.pdata = '0; bus.pstb = '0; bus.pwrite = 1'b0;
    bus.psel = 1'b1; bus.penable = 1'b0;

    // Reset state with a request already on the bus
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_sel", s_sel, 0);
    check("rst_s_enable", s_enable, 0);
    check("rst_pready", bus.pready, 0);
    check("rst_perr", bus.perr, 0);
    check("rst_prdata", bus.prdata, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_addr", err_addr, 0);
    @(posedge clk); #1;
    rts = 1'b0; bus.psel = 1'b0;

    // Write to slave0, ready in the first ACCESS cycle
    xfer(32'h0000_0010, 1'b1, 32'h0000_AAAA, 1'b0, 1'b0, w, rs, re);
    check("wr0_waits", w, 0);
    check("wr0_s_sel", rs, 4'b0001);
    check("wr0_s_enable", re, 4'b0001);

    // Read slave2 after three wait cycles
    slave_wait = 3;
    xfer(32'h9000_0004, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, w, rs, re);
    check("rd2_waits", w, 3);
    check("rd2_s_sel", rs, 4'b0100);

    // Read slave1 after one wait cycle
    slave_wait = 1;
    xfer(32'h8000_0100, 1'b0, 32'h1111_1111, 1'b0, 1'b0, w, rs, re);
    check("rd1_waits", w, 1);
    check("rd1_s_sel", rs, 4'b0010);

    // Slave-reported error is passed through but not recorded
    slave_wait = 2; s_perr = 4'b1000;
    xfer(32'hA000_0008, 1'b0, 32'h3333_3333, 1'b1, 1'b0, w, rs, re);
    s_perr = '0;
    check("rd3_waits", w, 2);
    check("rd3_s_sel", rs, 4'b1000);
    check("slverr_not_recorded", err_valid, 0);

    // Decode miss
    slave_wait = 0;
    xfer(32'hF000_0000, 1'b0, 32'h0, 1'b1, 1'b0, w, rs, re);
    check("miss_waits", w, 0);
    check("miss_s_sel", rs, 0);
    check("miss_s_enable", re, 0);
    check("miss_err_valid", err_valid, 1);
    check("miss_err_addr", err_addr, 32'hF000_0000);

    // Second miss keeps the first address
    xfer(32'hE000_0000, 1'b0, 32'h0, 1'b1, 1'b0, w, rs, re);
    check("miss2_err_valid", err_valid, 1);
    check("miss2_err_addr", err_addr, 32'hF000_0000);

    // Clear in the same cycle as a new miss: the new error wins
    xfer(32'hC000_0000, 1'b0, 32'h0, 1'b1, 1'b1, w, rs, re);
    check("clrmiss_err_valid", err_valid, 1);
    check("clrmiss_err_addr", err_addr, 32'hC000_0000);

    // Clear alone
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    check("clr_err_valid", err_valid, 0);

    // Ready on the cycle of the timeout terminal count completes normally
    slave_wait = 7;
    xfer(32'h8000_0040, 1'b0, 32'h1111_1111, 1'b0, 1'b0, w, rs, re);
    check("tc_ready_waits", w, 7);
    check("tc_ready_s_enable", re, 4'b0010);
    check("tc_ready_no_err", err_valid, 0);

`ifdef APB_ROUTER_TIMEOUT_EN
    // Unresponsive slave1: eight ACCESS cycles, then one ERR cycle
    slave_wait = 1000;
    xfer(32'h8000_0040, 1'b0, 32'h0, 1'b1, 1'b0, w, rs, re);
    check("to_waits", w, 8);
    check("to_s_sel", rs, 0);
    check("to_s_enable", re, 0);
    check("to_err_valid", err_valid, 1);
    check("to_err_addr", err_addr, 32'h8000_0040);
    slave_wait = 0;
    xfer(32'hF000_0000, 1'b0, 32'h0, 1'b1, 1'b0, w, rs, re);
    check("to_err_addr_kept", err_addr, 32'h8000_0040);
`endif

    // Reset during ACCESS to slave3
    slave_wait = 1000;
    @(posedge clk); #1;
    bus.paddr = 32'hA000_0000; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); #1; bus.penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_s_sel", s_sel, 4'b1000);
    check("pre_rst_s_enable", s_enable, 4'b1000);
    @(posedge clk); #1; rts = 1'b1;
    @(negedge clk);
    check("midrst_s_sel", s_sel, 0);
    check("midrst_s_enable", s_enable, 0);
    check("midrst_pready", bus.pready, 0);
    check("midrst_perr", bus.perr, 0);
    check("midrst_prdata", bus.prdata, 0);
    @(posedge clk); #1; rts = 1'b0;
    @(negedge clk);
    check("postrst_s_sel", s_sel, 0);
    check("postrst_err_valid", err_valid, 0);
    check("postrst_err_addr", err_addr, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("postrst_idle", s_sel, 0);
    @(posedge clk); #1; bus.psel = 1'b0; bus.penable = 1'b0;

    // psel dropped during ACCESS to slave1
    @(posedge clk); #1;
    bus.paddr = 32'h8000_0000; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); #1; bus.penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_pre_s_sel", s_sel, 4'b0010);
    @(posedge clk); #1; bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    check("drop_pready", bus.pready, 0);
    @(posedge clk); #1; bus.psel = 1'b1; bus.penable = 1'b1;
    @(negedge clk);
    check("drop_idle_s_sel", s_sel, 0);
    check("drop_err_valid", err_valid, 0);
    @(posedge clk); #1; bus.psel = 1'b0; bus.penable = 1'b0;

    // Recovery transfer
    slave_wait = 0;
    xfer(32'h0000_0020, 1'b0, 32'h0000_AAAA, 1'b0, 1'b0, w, rs, re);
    check("recover_waits", w, 0);
    check("recover_s_sel", rs, 4'b0001);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
